int_to_fp32_seq: RTL and testbench
==================================

Name: int_to_fp32_seq

Overview:
- Multi-cycle converter from a 32-bit two's-complement (or unsigned) integer to IEEE-754 single precision.
- Rounding is round-to-nearest-even.
- It produces the operands that feed the team's 32-bit float adder. It is the encode direction of the float datapath.
- Normalisation is iterative: one left shift per cycle. Input and output use valid/ready handshakes.

Parameters:
- SIGNED, 1: 1 means din is two's complement; 0 means din is unsigned.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  32  integer operand.
- in_valid  in  1  din is valid.
- in_ready  out  1  converter can accept an operand.
- dout  out  32  IEEE-754 single-precision result.
- out_valid  out  1  dout is valid.
- out_ready  in  1  consumer accepts dout.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=0, out_valid=0, dout=0, internal mag/sign/exponent registers=0.
  - in_ready is registered. It goes to 1 on the first rising edge after rst_n deasserts.
- States: IDLE, NORM, ROUND, DONE.
- in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE:
  - Accept occurs on the edge where in_valid && in_ready.
  - sign = SIGNED && din[31].
  - mag = sign ? -din : din, as an unsigned 32-bit value. 0x80000000 gives mag 0x80000000.
  - shift count cnt=0.
  - If din==0: dout=0x00000000, next state DONE. No NORM/ROUND cycles; +0 only.
  - Else: next state NORM.
- NORM:
  - If mag[31]==0: mag<<=1, cnt+=1, stay in NORM.
  - If mag[31]==1: go to ROUND.
  - NORM lasts lz+1 cycles, where lz = leading zeros of mag (0..31).
- ROUND:
  - exp = 158 - cnt (127+31-cnt).
  - frac = mag[30:8], guard = mag[7], sticky = |mag[6:0].
  - Round up iff guard && (sticky || frac[0]).
  - If frac rounds up from all ones: frac=0, exp+=1. Maximum result is 2^32; no overflow to Inf is possible.
  - dout = {sign, exp[7:0], frac}. Next state DONE.
- DONE:
  - dout and out_valid are held stable while out_ready=0.
  - On out_valid && out_ready: go to IDLE. in_ready returns to 1 the cycle after.
- Latency:
  - Nonzero din: out_valid asserts after edge lz+2 counted from the accept edge.
  - Zero din: out_valid asserts right after the accept edge.
- Throughput: one operation in flight. No new accept while busy or DONE.
- in_valid while in_ready=0 is ignored. din is sampled only on the accept edge; later changes do not affect the conversion.
- Reset mid-operation: the in-flight conversion is discarded and all outputs go to reset values immediately, asynchronously. No result is emitted after reset.
- Never produced: denormals, NaN, Inf, -0.

Test Plan:
1. SIGNED=1, rst_n pulse then din=1 -> dout=0x3F800000. out_valid rises 33 edges after accept (lz=31). in_ready=0 throughout.
2. SIGNED=1, sequence 2, -2, 3, 0 with out_ready=1 -> 0x40000000, 0xC0000000, 0x40400000, 0x00000000. The zero case gives out_valid one cycle after accept.
3. SIGNED=1, rounding checks:
   - 0x01000001 -> 0x4B800000 (tie to even, down).
   - 0x01000003 -> 0x4B800002 (tie, up).
   - 0x7FFFFFFF -> 0x4F000000 (carry into exponent).
   - 0x80000000 -> 0xCF000000.
4. SIGNED=0: 0xFFFFFFFF -> 0x4F800000 and 0x80000000 -> 0x4F000000.
5. Backpressure: hold out_ready=0 for 10 cycles after out_valid. dout is stable, in_valid pulses are ignored with in_ready=0. Raise out_ready: one transfer, then IDLE.
6. Drop rst_n during NORM of din=5 -> out_valid=0, dout=0 immediately. After release, in_ready=1 one edge later and no stale result appears. A new din=7 gives 0x40E00000.

Source files
------------

// File: rtl/int_to_fp32_seq.sv
// Sequential integer-to-IEEE-754 single-precision converter with iterative
// normalisation (one left shift per cycle) and round-to-nearest-even.
module int_to_fp32_seq #(
    parameter bit SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] din,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] dout,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic        sign_q, sign_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] dout_q, dout_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        din_sign_s;

    // Packs a normalised magnitude (hidden bit already stripped) into a float.
    // The exponent cannot exceed 159 even after a rounding carry.
    function automatic logic [31:0] pack_round(
        input logic        s,
        input logic [30:0] m,
        input logic [4:0]  c
    );
        logic [7:0]  exp_v;
        logic [23:0] frac_sum;
        logic        guard;
        logic        sticky;
        logic        up;
        exp_v    = 8'd158 - {3'd0, c};
        guard    = m[7];
        sticky   = |m[6:0];
        up       = guard & (sticky | m[8]);
        frac_sum = {1'b0, m[30:8]} + {23'd0, up};
        if (frac_sum[23]) begin
            exp_v = exp_v + 8'd1;
        end else begin
            exp_v = exp_v;
        end
        return {s, exp_v, frac_sum[22:0]};
    endfunction

    assign din_sign_s = SIGNED & din[31];

    // Next-state and datapath logic for the conversion FSM.
    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        sign_d  = sign_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    sign_d = din_sign_s;
                    mag_d  = din_sign_s ? (~din + 32'd1) : din;
                    cnt_d  = 5'd0;
                    if (din == 32'd0) begin
                        dout_d  = 32'd0;
                        state_d = DONE;
                    end else begin
                        state_d = NORM;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            NORM: begin
                if (mag_q[31]) begin
                    state_d = ROUND;
                end else begin
                    mag_d = {mag_q[30:0], 1'b0};
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ROUND: begin
                dout_d  = pack_round(sign_q, mag_q[30:0], cnt_q);
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Handshake flags are registered copies of the upcoming state.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mag_q       <= 32'd0;
            sign_q      <= 1'b0;
            cnt_q       <= 5'd0;
            dout_q      <= 32'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            sign_q      <= sign_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign dout      = dout_q;

endmodule

// File: tb/tb_int_to_fp32_seq.sv
// Directed self-checking bench for int_to_fp32_seq (signed and unsigned builds).
module tb_int_to_fp32_seq;

    logic        clk;
    logic        rst_n;
    logic [31:0] din_s, din_u;
    logic        in_valid_s, in_valid_u;
    logic        in_ready_s, in_ready_u;
    logic [31:0] dout_s, dout_u;
    logic        out_valid_s, out_valid_u;
    logic        out_ready_s, out_ready_u;

    int n_checks;
    int n_fail;

    int_to_fp32_seq #(.SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .din(din_s), .in_valid(in_valid_s),
        .in_ready(in_ready_s), .dout(dout_s), .out_valid(out_valid_s),
        .out_ready(out_ready_s)
    );

    int_to_fp32_seq #(.SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .din(din_u), .in_valid(in_valid_u),
        .in_ready(in_ready_u), .dout(dout_u), .out_valid(out_valid_u),
        .out_ready(out_ready_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operand into the chosen DUT, then scrambles din.
    // lat counts edges after the accept edge until out_valid is seen.
    task automatic run_op(input bit use_u, input logic [31:0] d,
                          output logic [31:0] res, output int lat,
                          output bit saw_ready, output bit timeout);
        int w;
        w = 0;
        timeout = 1'b0;
        saw_ready = 1'b0;
        while (!(use_u ? in_ready_u : in_ready_s) && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (use_u) begin din_u = d; in_valid_u = 1'b1; end
        else begin din_s = d; in_valid_s = 1'b1; end
        @(posedge clk); #1;
        in_valid_s = 1'b0; in_valid_u = 1'b0;
        din_s = 32'hDEADBEEF; din_u = 32'hDEADBEEF;
        lat = 0;
        while (!(use_u ? out_valid_u : out_valid_s) && lat < 100) begin
            if (use_u ? in_ready_u : in_ready_s) saw_ready = 1'b1;
            @(posedge clk); #1; lat++;
        end
        if (use_u ? in_ready_u : in_ready_s) saw_ready = 1'b1;
        if (lat >= 100) timeout = 1'b1;
        res = use_u ? dout_u : dout_s;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready_s !== 1'b0 || out_valid_s !== 1'b0 || dout_s !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b dout=%h, required 0 0 00000000",
                     in_ready_s, out_valid_s, dout_s);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready_s !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold_ready: in_ready=%b, required 0", in_ready_s);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready_s !== 1'b1 || in_ready_u !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: in_ready=%b/%b, required 1/1", in_ready_s, in_ready_u);
        end
    endtask

    task automatic test_one;
        logic [31:0] r; int lat; bit sr, to;
        run_op(1'b0, 32'd1, r, lat, sr, to);
        n_checks++;
        if (r !== 32'h3F800000 || to) begin
            n_fail++;
            $display("FAIL one_value: dout=%h timeout=%b, required 3f800000", r, to);
        end
        n_checks++;
        if (lat != 33) begin
            n_fail++;
            $display("FAIL one_latency: edges=%0d, required 33", lat);
        end
        n_checks++;
        if (sr) begin
            n_fail++;
            $display("FAIL one_busy_ready: in_ready rose while busy, required 0");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sequence;
        logic [31:0] vin [4] = '{32'd2, 32'hFFFFFFFE, 32'd3, 32'd0};
        logic [31:0] vexp[4] = '{32'h40000000, 32'hC0000000, 32'h40400000, 32'h00000000};
        int          vlat[4] = '{32, 32, 32, 0};
        logic [31:0] r; int lat; bit sr, to;
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, vin[i], r, lat, sr, to);
            n_checks++;
            if (r !== vexp[i] || lat != vlat[i] || to) begin
                n_fail++;
                $display("FAIL seq_%0d: din=%h dout=%h lat=%0d, required %h lat=%0d",
                         i, vin[i], r, lat, vexp[i], vlat[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rounding;
        logic [31:0] vin [4] = '{32'h01000001, 32'h01000003, 32'h7FFFFFFF, 32'h80000000};
        logic [31:0] vexp[4] = '{32'h4B800000, 32'h4B800002, 32'h4F000000, 32'hCF000000};
        logic [31:0] r; int lat; bit sr, to;
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, vin[i], r, lat, sr, to);
            n_checks++;
            if (r !== vexp[i] || to) begin
                n_fail++;
                $display("FAIL round_%0d: din=%h dout=%h, required %h", i, vin[i], r, vexp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_unsigned;
        logic [31:0] vin [2] = '{32'hFFFFFFFF, 32'h80000000};
        logic [31:0] vexp[2] = '{32'h4F800000, 32'h4F000000};
        logic [31:0] r; int lat; bit sr, to;
        for (int i = 0; i < 2; i++) begin
            run_op(1'b1, vin[i], r, lat, sr, to);
            n_checks++;
            if (r !== vexp[i] || lat != 2 || to) begin
                n_fail++;
                $display("FAIL unsigned_%0d: din=%h dout=%h lat=%0d, required %h lat=2",
                         i, vin[i], r, lat, vexp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] r; int lat; bit sr, to; bit bad;
        out_ready_s = 1'b0;
        run_op(1'b0, 32'd3, r, lat, sr, to);
        n_checks++;
        if (r !== 32'h40400000 || to) begin
            n_fail++;
            $display("FAIL bp_value: dout=%h, required 40400000", r);
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            din_s = 32'd100 + i; in_valid_s = i[0];
            @(posedge clk); #1;
            if (dout_s !== 32'h40400000 || out_valid_s !== 1'b1 || in_ready_s !== 1'b0) bad = 1'b1;
        end
        in_valid_s = 1'b0;
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL bp_hold: dout=%h out_valid=%b in_ready=%b, required 40400000 1 0",
                     dout_s, out_valid_s, in_ready_s);
        end
        out_ready_s = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid_s, in_ready_s);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_idle: out_valid=%b in_ready=%b, required 0 1", out_valid_s, in_ready_s);
        end
    endtask

    task automatic test_reset_midop;
        logic [31:0] r; int lat; bit sr, to; bit stale;
        din_s = 32'd5; in_valid_s = 1'b1;
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid_s !== 1'b0 || dout_s !== 32'd0 || in_ready_s !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_reset: out_valid=%b dout=%h in_ready=%b, required 0 00000000 0",
                     out_valid_s, dout_s, in_ready_s);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready_s !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_ready: in_ready=%b, required 1", in_ready_s);
        end
        stale = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1) stale = 1'b1;
        end
        n_checks++;
        if (stale) begin
            n_fail++;
            $display("FAIL midop_stale: out_valid=%b in_ready=%b, required 0 1", out_valid_s, in_ready_s);
        end
        run_op(1'b0, 32'd7, r, lat, sr, to);
        n_checks++;
        if (r !== 32'h40E00000 || lat != 31 || to) begin
            n_fail++;
            $display("FAIL midop_next: dout=%h lat=%0d, required 40e00000 lat=31", r, lat);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        din_s = 32'd0; din_u = 32'd0;
        in_valid_s = 1'b0; in_valid_u = 1'b0;
        out_ready_s = 1'b1; out_ready_u = 1'b1;
        rst_n = 1'b1;
        test_reset;
        test_one;
        test_sequence;
        test_rounding;
        test_unsigned;
        test_backpressure;
        test_reset_midop;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
